// File: rtl/tc_pcie_block_align_ctrl.sv
// Per-lane 128b/130b block-lock sequencer: IDLE -> FLUSH -> HUNT -> VERIFY -> LOCKED; Moore outputs, 1-cycle registered event pulses, no backpressure.
// Optional stats counters (lock losses, hunt timeouts) are compiled in with TC_PCIE_BA_CTRL_STATS_EN.
module tc_pcie_block_align_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int HUNT_TIMEOUT = 4096,
  parameter int LOCK_CNT     = 8,
  parameter int ERR_WINDOW   = 64,
  parameter int UNLOCK_ERR   = 4
) (
  input  logic       rxclk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [2:0] rate_i,
  input  logic       align_valid_i,
  input  logic       eieos_det_i,
  input  logic       block_strobe_i,
  input  logic       sync_hdr_err_i,
  output logic       blockalign_enable_o,
  output logic       aligner_flush_o,
  output logic       block_lock_o,
  output logic       timeout_o,
  output logic       lock_lost_o,
  output logic [2:0] state_o
`ifdef TC_PCIE_BA_CTRL_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt_o,
  output logic [15:0] hunt_timeout_cnt_o
`endif
);

  localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TMR_W  = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
  localparam int GOOD_W = (LOCK_CNT     > 1) ? $clog2(LOCK_CNT)     : 1;
  localparam int BLK_W  = (ERR_WINDOW   > 1) ? $clog2(ERR_WINDOW)   : 1;
  localparam int ERR_W  = (UNLOCK_ERR   > 1) ? $clog2(UNLOCK_ERR)   : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(HUNT_TIMEOUT - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(ERR_WINDOW - 1);
  localparam logic [ERR_W:0]    ERR_LIM   = (ERR_W + 1)'(UNLOCK_ERR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_HUNT   = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [2:0]        r_rate;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [GOOD_W-1:0] r_good;
  logic [BLK_W-1:0]  r_blk;
  logic [ERR_W-1:0]  r_err;
  logic              r_timeout;
  logic              r_lock_lost;

  logic              w_rate_ok;
  logic              w_enter;
  logic              w_tmo;
  logic              w_lost_evt;
  logic              w_wrap;
  logic [ERR_W:0]    w_err_nxt;

  assign w_rate_ok  = (rate_i == 3'd2) || (rate_i == 3'd3) || (rate_i == 3'd4);
  assign w_wrap     = (r_blk == BLK_LAST);
  // The wrapping block's error opens the next window rather than closing the current one.
  assign w_err_nxt  = w_wrap ? {ERR_W'(0), sync_hdr_err_i}
                             : ({1'b0, r_err} + (ERR_W + 1)'(sync_hdr_err_i));
  assign w_lost_evt = (r_state == S_LOCKED) && (w_nxt != S_LOCKED);

  // w_enter marks every transition, including FLUSH restarting itself on a rate change.
  always_comb begin
    w_nxt   = r_state;
    w_enter = 1'b0;
    w_tmo   = 1'b0;
    if (!enable_i || !w_rate_ok) begin
      w_nxt   = S_IDLE;
      w_enter = (r_state != S_IDLE);
    end else if ((rate_i != r_rate) && (r_state != S_IDLE)) begin
      w_nxt   = S_FLUSH;
      w_enter = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt   = S_FLUSH;
          w_enter = 1'b1;
        end
        S_FLUSH: begin
          if (r_cnt == CNT_LAST) begin
            w_nxt   = S_HUNT;
            w_enter = 1'b1;
          end
        end
        S_HUNT: begin
          if (eieos_det_i && align_valid_i) begin
            w_nxt   = S_VERIFY;
            w_enter = 1'b1;
          end else if (r_timer == TMR_LAST) begin
            w_nxt   = S_FLUSH;
            w_enter = 1'b1;
            w_tmo   = 1'b1;
          end
        end
        S_VERIFY: begin
          if (block_strobe_i) begin
            if (sync_hdr_err_i) begin
              w_nxt   = S_FLUSH;
              w_enter = 1'b1;
            end else if (r_good == GOOD_LAST) begin
              w_nxt   = S_LOCKED;
              w_enter = 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (block_strobe_i && sync_hdr_err_i && (w_err_nxt == ERR_LIM)) begin
            w_nxt   = S_FLUSH;
            w_enter = 1'b1;
          end
        end
        default: begin
          w_nxt   = S_IDLE;
          w_enter = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge rxclk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_rate      <= 3'd0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_good      <= '0;
      r_blk       <= '0;
      r_err       <= '0;
      r_timeout   <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_rate      <= rate_i;
      r_timeout   <= w_tmo;
      r_lock_lost <= w_lost_evt;
      if (w_enter) begin
        r_cnt   <= '0;
        r_timer <= '0;
        r_good  <= '0;
        r_blk   <= '0;
        r_err   <= '0;
      end else begin
        case (r_state)
          S_FLUSH: begin
            if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
          end
          S_HUNT: begin
            if (r_timer != TMR_LAST) r_timer <= r_timer + 1'b1;
          end
          S_VERIFY: begin
            if (block_strobe_i && !sync_hdr_err_i && (r_good != GOOD_LAST))
              r_good <= r_good + 1'b1;
          end
          S_LOCKED: begin
            if (block_strobe_i) begin
              r_blk <= w_wrap ? '0 : r_blk + 1'b1;
              r_err <= w_err_nxt[ERR_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state_o             = r_state;
  assign aligner_flush_o     = (r_state == S_FLUSH);
  assign blockalign_enable_o = (r_state == S_HUNT) || (r_state == S_VERIFY);
  assign block_lock_o        = (r_state == S_LOCKED);
  assign timeout_o           = r_timeout;
  assign lock_lost_o         = r_lock_lost;

`ifdef TC_PCIE_BA_CTRL_STATS_EN
  logic [15:0] r_lock_loss_cnt;
  logic [15:0] r_hunt_tmo_cnt;

  always_ff @(posedge rxclk_i) begin
    if (reset_i) begin
      r_lock_loss_cnt <= 16'd0;
      r_hunt_tmo_cnt  <= 16'd0;
    end else begin
      if (w_lost_evt && (r_lock_loss_cnt != 16'hFFFF)) r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
      if (w_tmo && (r_hunt_tmo_cnt != 16'hFFFF))      r_hunt_tmo_cnt  <= r_hunt_tmo_cnt + 16'd1;
    end
  end

  assign lock_loss_cnt_o    = r_lock_loss_cnt;
  assign hunt_timeout_cnt_o = r_hunt_tmo_cnt;
`endif

endmodule

// File: tb/tb_tc_pcie_block_align_ctrl.sv
// Directed bench for tc_pcie_block_align_ctrl: expected per-cycle outputs are queued as stimulus is driven and popped after each edge.
module tb_tc_pcie_block_align_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FLUSH  = 3'd1;
  localparam logic [2:0] ST_HUNT   = 3'd2;
  localparam logic [2:0] ST_VERIFY = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;

  logic       rxclk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic [2:0] rate_i;
  logic       align_valid_i;
  logic       eieos_det_i;
  logic       block_strobe_i;
  logic       sync_hdr_err_i;
  logic       blockalign_enable_o;
  logic       aligner_flush_o;
  logic       block_lock_o;
  logic       timeout_o;
  logic       lock_lost_o;
  logic [2:0] state_o;
`ifdef TC_PCIE_BA_CTRL_STATS_EN
  logic [15:0] lock_loss_cnt_o;
  logic [15:0] hunt_timeout_cnt_o;
`endif

  tc_pcie_block_align_ctrl dut (
    .rxclk_i             (rxclk_i),
    .reset_i             (reset_i),
    .enable_i            (enable_i),
    .rate_i              (rate_i),
    .align_valid_i       (align_valid_i),
    .eieos_det_i         (eieos_det_i),
    .block_strobe_i      (block_strobe_i),
    .sync_hdr_err_i      (sync_hdr_err_i),
    .blockalign_enable_o (blockalign_enable_o),
    .aligner_flush_o     (aligner_flush_o),
    .block_lock_o        (block_lock_o),
    .timeout_o           (timeout_o),
    .lock_lost_o         (lock_lost_o),
    .state_o             (state_o)
`ifdef TC_PCIE_BA_CTRL_STATS_EN
    ,
    .lock_loss_cnt_o     (lock_loss_cnt_o),
    .hunt_timeout_cnt_o  (hunt_timeout_cnt_o)
`endif
  );

  always #5 rxclk_i = ~rxclk_i;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         total = 0;
  int         bad   = 0;

  // Expected vector: {state, blockalign_enable, flush, block_lock, timeout, lock_lost}
  task automatic push(input string tag, input logic [2:0] st, input logic tmo, input logic lost);
    logic [7:0] e;
    e = {st, (st == ST_HUNT) || (st == ST_VERIFY), st == ST_FLUSH, st == ST_LOCKED, tmo, lost};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run(input int n);
    logic [7:0] e;
    logic [7:0] obs;
    string      t;
    for (int i = 0; i < n; i++) begin
      @(posedge rxclk_i);
      #1;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_empty observed_depth=%0d expected_depth>0", exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {state_o, blockalign_enable_o, aligner_flush_o, block_lock_o, timeout_o, lock_lost_o};
        assert (obs === e) else begin
          bad++;
          $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic tmo, input logic lost);
    push(tag, st, tmo, lost);
    run(1);
  endtask

  task automatic strobe_blk(input logic err, input string tag, input logic [2:0] st, input logic lost);
    block_strobe_i = 1'b1;
    sync_hdr_err_i = err;
    step(tag, st, 1'b0, lost);
    block_strobe_i = 1'b0;
    sync_hdr_err_i = 1'b0;
  endtask

  // Expects the next edge to enter FLUSH; FLUSH lasts four cycles, then HUNT.
  task automatic flush_to_hunt(input string tag, input logic tmo, input logic lost);
    push(tag, ST_FLUSH, tmo, lost);
    for (int i = 0; i < 3; i++) push(tag, ST_FLUSH, 1'b0, 1'b0);
    push({tag, "_hunt"}, ST_HUNT, 1'b0, 1'b0);
    run(5);
  endtask

  task automatic lock_up(input string tag);
    eieos_det_i   = 1'b1;
    align_valid_i = 1'b1;
    step({tag, "_detect"}, ST_VERIFY, 1'b0, 1'b0);
    eieos_det_i   = 1'b0;
    align_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) strobe_blk(1'b0, {tag, "_good"}, ST_VERIFY, 1'b0);
    strobe_blk(1'b0, {tag, "_lock"}, ST_LOCKED, 1'b0);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset_i        = 1'b1;
    enable_i       = 1'b0;
    rate_i         = 3'd0;
    align_valid_i  = 1'b0;
    eieos_det_i    = 1'b0;
    block_strobe_i = 1'b0;
    sync_hdr_err_i = 1'b0;
    push("reset", ST_IDLE, 1'b0, 1'b0);
    push("reset", ST_IDLE, 1'b0, 1'b0);
    run(2);

    reset_i  = 1'b0;
    enable_i = 1'b1;
    rate_i   = 3'd2;
    flush_to_hunt("startup", 1'b0, 1'b0);

    eieos_det_i = 1'b1;
    step("eieos_without_valid", ST_HUNT, 1'b0, 1'b0);
    eieos_det_i   = 1'b0;
    eieos_det_i   = 1'b1;
    align_valid_i = 1'b1;
    step("detect", ST_VERIFY, 1'b0, 1'b0);
    eieos_det_i   = 1'b0;
    align_valid_i = 1'b0;
    sync_hdr_err_i = 1'b1;
    step("err_without_strobe", ST_VERIFY, 1'b0, 1'b0);
    sync_hdr_err_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      strobe_blk(1'b0, "verify_good", ST_VERIFY, 1'b0);
      step("verify_gap", ST_VERIFY, 1'b0, 1'b0);
    end
    strobe_blk(1'b0, "lock_after_8th", ST_LOCKED, 1'b0);

    // Two windows of three errors each must hold lock only if err reloads on wrap.
    for (int i = 0; i < 64; i++) strobe_blk((i == 1) || (i == 10) || (i == 20), "window_a", ST_LOCKED, 1'b0);
    for (int i = 0; i < 64; i++) strobe_blk((i >= 2) && (i <= 4), "window_b", ST_LOCKED, 1'b0);
    for (int i = 0; i < 3; i++) strobe_blk(1'b1, "window_c", ST_LOCKED, 1'b0);
    block_strobe_i = 1'b1;
    sync_hdr_err_i = 1'b1;
    push("unlock_4th_err", ST_FLUSH, 1'b0, 1'b1);
    run(1);
    block_strobe_i = 1'b0;
    sync_hdr_err_i = 1'b0;
    for (int i = 0; i < 3; i++) push("unlock_flush", ST_FLUSH, 1'b0, 1'b0);
    push("unlock_hunt", ST_HUNT, 1'b0, 1'b0);
    run(4);

    lock_up("relock1");
    rate_i = 3'd3;
    flush_to_hunt("rate_change_locked", 1'b0, 1'b1);

    rate_i = 3'd4;
    flush_to_hunt("rate_change_hunt", 1'b0, 1'b0);

    lock_up("relock2");
    enable_i = 1'b0;
    step("disable", ST_IDLE, 1'b0, 1'b1);
    step("disabled", ST_IDLE, 1'b0, 1'b0);
    rate_i = 3'd5;
    enable_i = 1'b1;
    step("bad_rate", ST_IDLE, 1'b0, 1'b0);
    rate_i = 3'd3;

    flush_to_hunt("reenable", 1'b0, 1'b0);
    for (int i = 0; i < 4095; i++) push("hunt_wait", ST_HUNT, 1'b0, 1'b0);
    run(4095);
    flush_to_hunt("hunt_timeout", 1'b1, 1'b0);
    for (int i = 0; i < 4095; i++) push("hunt_wait2", ST_HUNT, 1'b0, 1'b0);
    run(4095);
    eieos_det_i   = 1'b1;
    align_valid_i = 1'b1;
    step("detect_beats_timeout", ST_VERIFY, 1'b0, 1'b0);
    eieos_det_i   = 1'b0;
    align_valid_i = 1'b0;

    strobe_blk(1'b0, "verify_good2", ST_VERIFY, 1'b0);
    block_strobe_i = 1'b1;
    sync_hdr_err_i = 1'b1;
    flush_to_hunt("verify_err", 1'b0, 1'b0);
    block_strobe_i = 1'b0;
    sync_hdr_err_i = 1'b0;

    eieos_det_i   = 1'b1;
    align_valid_i = 1'b1;
    step("detect3", ST_VERIFY, 1'b0, 1'b0);
    eieos_det_i   = 1'b0;
    align_valid_i = 1'b0;
    strobe_blk(1'b0, "verify_good3", ST_VERIFY, 1'b0);

`ifdef TC_PCIE_BA_CTRL_STATS_EN
    chk16("lock_loss_cnt", lock_loss_cnt_o, 16'd3);
    chk16("hunt_timeout_cnt", hunt_timeout_cnt_o, 16'd1);
`endif

    reset_i = 1'b1;
    step("reset_mid_verify", ST_IDLE, 1'b0, 1'b0);
`ifdef TC_PCIE_BA_CTRL_STATS_EN
    chk16("lock_loss_cnt_reset", lock_loss_cnt_o, 16'd0);
    chk16("hunt_timeout_cnt_reset", hunt_timeout_cnt_o, 16'd0);
`endif
    chk16("leftover_expectations", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
